// File: rtl/fc_feeder_pkg.sv
// Shared definitions for the FC-layer feeder: FSM encoding and IEEE-754 constants.
package fc_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } fc_state_e;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/fc_row_buffer.sv
// Row buffer with synchronous write and registered read; the read register
// returns zero when no read is requested, and forwards a same-edge write.
module fc_row_buffer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Forwarding lets a write landing on the go edge be streamed immediately.
  always_ff @(posedge clk) begin
    if (reset || !i_rd_en)                          r_rd_data <= '0;
    else if (i_wr_en && (i_wr_addr == i_rd_addr))   r_rd_data <= i_wr_data;
    else                                            r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fc_feeder.sv
// Streams buffered input elements and weight rows into a PE array, waits for
// the array to drain, then captures its accumulated outputs.
module fc_feeder
  import fc_feeder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned PARALLEL_FC_PE = 32,
  parameter int unsigned NUM_INPUTS     = 16,
  parameter int unsigned DRAIN_CYCLES   = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_wr_en,
  input  logic [$clog2(NUM_INPUTS)-1:0]          in_wr_addr,
  input  logic [DATA_WIDTH-1:0]                  in_wr_data,
  input  logic                                   w_wr_en,
  input  logic [$clog2(NUM_INPUTS)-1:0]          w_wr_addr,
  input  logic [DATA_WIDTH*PARALLEL_FC_PE-1:0]   w_wr_data,
  input  logic                                   go,
  output logic [DATA_WIDTH-1:0]                  input_fc,
  output logic [DATA_WIDTH*PARALLEL_FC_PE-1:0]   weightCaches_fc,
  output logic                                   start_FC,
  input  logic [DATA_WIDTH*PARALLEL_FC_PE-1:0]   output_fc,
  output logic [DATA_WIDTH*PARALLEL_FC_PE-1:0]   result,
  output logic                                   result_valid,
  output logic                                   busy
);

  localparam int unsigned AW = $clog2(NUM_INPUTS);
  localparam int unsigned WW = DATA_WIDTH * PARALLEL_FC_PE;
  localparam int unsigned CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [AW-1:0] LAST_ROW   = AW'(NUM_INPUTS - 1);
  localparam logic [CW-1:0] LAST_DRAIN = CW'(DRAIN_CYCLES - 1);

  fc_state_e     r_state, w_state_nxt;
  logic [AW-1:0] r_row, w_row_nxt;
  logic [CW-1:0] r_drain, w_drain_nxt;
  logic          w_rd_en;
  logic [AW-1:0] w_rd_addr;
  logic          w_wr_ok;
  logic          w_in_we, w_wt_we;

  logic          r_start;
  logic          r_busy;
  logic          r_result_valid;
  logic [WW-1:0] r_result;

  // Buffers only accept writes while idle and not being reset.
  assign w_wr_ok = (r_state == ST_IDLE) && !reset;
  assign w_in_we = in_wr_en && w_wr_ok;
  assign w_wt_we = w_wr_en && w_wr_ok;

  fc_row_buffer #(.WIDTH(DATA_WIDTH), .DEPTH(NUM_INPUTS)) u_in_buf (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_in_we),
    .i_wr_addr (in_wr_addr),
    .i_wr_data (in_wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (input_fc)
  );

  fc_row_buffer #(.WIDTH(WW), .DEPTH(NUM_INPUTS)) u_w_buf (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wt_we),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (weightCaches_fc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  // The read issued on each edge becomes the row presented in the next cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_drain_nxt = r_drain;
    w_rd_en     = 1'b0;
    w_rd_addr   = r_row;
    unique case (r_state)
      ST_IDLE: begin
        if (go) begin
          w_state_nxt = ST_STREAM;
          w_row_nxt   = '0;
          w_rd_en     = 1'b1;
          w_rd_addr   = '0;
        end
      end
      ST_STREAM: begin
        if (r_row == LAST_ROW) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = '0;
        end else begin
          w_row_nxt = r_row + AW'(1);
          w_rd_en   = 1'b1;
          w_rd_addr = r_row + AW'(1);
        end
      end
      ST_DRAIN: begin
        if (r_drain == LAST_DRAIN) begin
          w_state_nxt = ST_DONE;
          w_drain_nxt = '0;
        end else begin
          w_drain_nxt = r_drain + CW'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_row_nxt   = '0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_start        <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result       <= '0;
    end else begin
      r_start        <= (w_state_nxt == ST_STREAM);
      r_busy         <= (w_state_nxt != ST_IDLE);
      r_result_valid <= (w_state_nxt == ST_DONE);
      if (w_state_nxt == ST_DONE) r_result <= output_fc;
    end
  end

  assign start_FC     = r_start;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign result       = r_result;

endmodule

// File: tb/tb_fc_feeder.sv
// Scoreboard bench for fc_feeder: a pass-level model predicts rows and results.
module tb_fc_feeder;

  localparam int unsigned DW = 32;
  localparam int unsigned PE = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned WW = DW * PE;

  logic          clk = 1'b0;
  logic          reset, in_wr_en, w_wr_en, go;
  logic [AW-1:0] in_wr_addr, w_wr_addr;
  logic [DW-1:0] in_wr_data, input_fc;
  logic [WW-1:0] w_wr_data, weightCaches_fc, output_fc, result;
  logic          start_FC, result_valid, busy;

  fc_feeder #(.DATA_WIDTH(DW), .PARALLEL_FC_PE(PE), .NUM_INPUTS(N), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .reset(reset),
    .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_wr_data(in_wr_data),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .go(go), .input_fc(input_fc), .weightCaches_fc(weightCaches_fc), .start_FC(start_FC),
    .output_fc(output_fc), .result(result), .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] in;
    logic [WW-1:0] w;
  } row_t;

  row_t          exp_row_q[$];
  logic [WW-1:0] exp_res_q[$];
  logic [DW-1:0] m_in [N];
  logic [WW-1:0] m_w  [N];
  logic [WW-1:0] hold_res = '0;
  int            m_busy = 0, m_busy_nxt = 0;
  bit            flush_req = 1'b0, mon_en = 1'b0;
  int            total = 0, bad = 0;

  bit            d_rst, d_go, d_iwe, d_wwe;
  int            d_ia, d_wa;
  logic [DW-1:0] d_id;
  logic [WW-1:0] d_wd, d_ofc;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_drive();
    d_rst = 1'b0; d_go = 1'b0; d_iwe = 1'b0; d_wwe = 1'b0;
    d_ia = 0; d_wa = 0; d_id = '0; d_wd = '0;
  endtask

  function automatic logic [WW-1:0] rand_wide();
    logic [WW-1:0] v;
    for (int i = 0; i < int'(PE); i++) v[i*DW +: DW] = $urandom();
    return v;
  endfunction

  // One clock cycle: drive inputs, advance the pass-level model, wait for the edge.
  task automatic step();
    m_busy     = m_busy_nxt;
    reset      = d_rst;
    go         = d_go;
    in_wr_en   = d_iwe;
    in_wr_addr = AW'(d_ia);
    in_wr_data = d_id;
    w_wr_en    = d_wwe;
    w_wr_addr  = AW'(d_wa);
    w_wr_data  = d_wd;
    output_fc  = d_ofc;
    if (d_rst) begin
      m_busy_nxt = 0;
      flush_req  = 1'b1;
    end else if (m_busy == 0) begin
      if (d_iwe) m_in[d_ia] = d_id;
      if (d_wwe) m_w[d_wa]  = d_wd;
      if (d_go) begin
        for (int k = 0; k < int'(N); k++) exp_row_q.push_back('{m_in[k], m_w[k]});
        m_busy_nxt = int'(N + D) + 1;
      end else begin
        m_busy_nxt = 0;
      end
    end else begin
      if (m_busy == 2) exp_res_q.push_back(d_ofc);
      m_busy_nxt = m_busy - 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Busy window per pass: N stream cycles, D drain cycles, one done cycle.
  always @(negedge clk) begin
    row_t r;
    logic [WW-1:0] er;
    if (mon_en) begin
      check("busy", WW'(busy), WW'(m_busy > 0));
      check("start_FC", WW'(start_FC), WW'(m_busy > int'(D) + 1));
      check("result_valid", WW'(result_valid), WW'(m_busy == 1));
      if (start_FC) begin
        if (exp_row_q.size() == 0) begin
          total++; bad++;
          $display("FAIL row_unexpected: start_FC=1 with no row pending");
        end else begin
          r = exp_row_q.pop_front();
          check("input_fc", WW'(input_fc), WW'(r.in));
          check("weightCaches_fc", weightCaches_fc, r.w);
        end
      end else begin
        check("input_fc_idle", WW'(input_fc), '0);
        check("weights_idle", weightCaches_fc, '0);
      end
      if (result_valid) begin
        if (exp_res_q.size() == 0) begin
          total++; bad++;
          $display("FAIL result_unexpected: result_valid=1 with no result pending");
        end else begin
          er = exp_res_q.pop_front();
          check("result", result, er);
          hold_res = er;
        end
      end else begin
        check("result_hold", result, hold_res);
      end
    end
    if (flush_req) begin
      exp_row_q.delete();
      exp_res_q.delete();
      hold_res  = '0;
      flush_req = 1'b0;
    end
  end

  initial begin
    logic [DW-1:0] fp_tab [N];
    logic [WW-1:0] a5;
    logic [WW-1:0] v;
    fp_tab[0] = 32'h3F80_0000; fp_tab[1] = 32'h4000_0000;
    fp_tab[2] = 32'h4040_0000; fp_tab[3] = 32'h4080_0000;
    a5 = {(WW/8){8'hA5}};

    clear_drive();
    d_ofc = '0;
    d_rst = 1'b1;
    step();
    mon_en = 1'b1;
    step();
    clear_drive();

    // Load 1.0..4.0 and the k*32+i weight pattern.
    for (int k = 0; k < int'(N); k++) begin
      for (int i = 0; i < int'(PE); i++) v[i*DW +: DW] = DW'(k * 32 + i);
      d_iwe = 1'b1; d_ia = k; d_id = fp_tab[k];
      d_wwe = 1'b1; d_wa = k; d_wd = v;
      step();
    end
    clear_drive();

    // Directed pass, then back-to-back go right after result_valid.
    d_ofc = a5;
    d_go = 1'b1; step(); clear_drive();
    for (int c = 1; c <= 9; c++) step();
    d_ofc = ~a5;
    d_go = 1'b1; step(); clear_drive();
    for (int c = 1; c <= 10; c++) step();

    // go and weight write during a pass are ignored.
    d_ofc = rand_wide();
    for (int c = 0; c <= 12; c++) begin
      clear_drive();
      if (c == 0 || c == 2 || c == 6) d_go = 1'b1;
      if (c == 3) begin d_wwe = 1'b1; d_wa = 1; d_wd = rand_wide(); end
      if (c == 4) begin d_iwe = 1'b1; d_ia = 2; d_id = $urandom(); end
      step();
    end
    clear_drive();

    // Reset at stream cycle 2 aborts; a fresh go completes.
    d_go = 1'b1; step(); clear_drive();
    step();
    d_rst = 1'b1; step(); clear_drive();
    step();
    d_go = 1'b1; step(); clear_drive();
    for (int c = 1; c <= 11; c++) step();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      clear_drive();
      d_ofc = rand_wide();
      d_rst = ($urandom_range(0, 99) < 2);
      d_go  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 2) == 0) begin
        d_iwe = 1'b1; d_ia = int'($urandom_range(0, N - 1)); d_id = $urandom();
      end
      if ($urandom_range(0, 2) == 0) begin
        d_wwe = 1'b1; d_wa = int'($urandom_range(0, N - 1)); d_wd = rand_wide();
      end
      step();
    end
    clear_drive();
    for (int c = 0; c < 16; c++) step();

    check("rows_left", WW'(exp_row_q.size()), '0);
    check("results_left", WW'(exp_res_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
